// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe turn controller and its helpers.
package ttt_pkg;

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'b00,
        CELL_P1    = 2'b01,
        CELL_P2    = 2'b10
    } cell_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10,
        WIN_DRAW = 2'b11
    } winner_t;

    typedef enum logic [1:0] {
        P1_TURN,
        P2_TURN,
        CHECK,
        DONE
    } state_t;

    localparam int NUM_LINES = 8;

    // Rows, then columns, then the two diagonals, as row-major cell indices.
    localparam int WIN_LINES [NUM_LINES][3] = '{
        '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
        '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
        '{0, 4, 8}, '{2, 4, 6}
    };

endpackage

// File: rtl/ttt_line_check.sv
// Combinational detector: reports whether the given mark fills any complete line.
module ttt_line_check
    import ttt_pkg::*;
(
    input  logic [17:0] board,
    input  cell_t       mark,
    output logic        owns
);

    // An empty mark never owns a line, so the block is safe to reuse with any mark.
    always_comb begin
        owns = 1'b0;
        for (int l = 0; l < NUM_LINES; l++) begin
            if (mark != CELL_EMPTY &&
                board[2*WIN_LINES[l][0] +: 2] == mark &&
                board[2*WIN_LINES[l][1] +: 2] == mark &&
                board[2*WIN_LINES[l][2] +: 2] == mark) begin
                owns = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ttt_turn_ctrl.sv
// Turn sequencer and move arbiter: validates placements on the shared board,
// writes the mover's mark, then scores the board and hands the turn over.
module ttt_turn_ctrl
    import ttt_pkg::*;
#(
    parameter int CELLS = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 place,
    input  logic [3:0]           cursor,
    input  logic                 new_game,
    output logic [2*CELLS-1:0]   board,
    output logic                 player1,
    output logic                 player2,
    output logic [1:0]           winner,
    output logic                 game_over,
    output logic                 invalid
);

    state_t             state, state_next;
    cell_t              mover, mover_next;
    cell_t              mark;
    winner_t            winner_r, winner_next;
    logic [2*CELLS-1:0] board_next;
    logic               invalid_next;
    logic               place_q;
    logic               place_edge;
    logic               cursor_ok;
    logic               target_empty;
    logic               board_full;
    logic               p1_line;
    logic               p2_line;
    logic               mover_won;

    ttt_line_check u_check_p1 (
        .board (board),
        .mark  (CELL_P1),
        .owns  (p1_line)
    );

    ttt_line_check u_check_p2 (
        .board (board),
        .mark  (CELL_P2),
        .owns  (p2_line)
    );

    always_comb begin
        place_edge   = place & ~place_q;
        cursor_ok    = (cursor <= 4'd8);
        mark         = (state == P2_TURN) ? CELL_P2 : CELL_P1;
        mover_won    = (mover == CELL_P1) ? p1_line : p2_line;
        target_empty = 1'b0;
        board_full   = 1'b1;
        for (int i = 0; i < CELLS; i++) begin
            if (board[2*i +: 2] == CELL_EMPTY) begin
                board_full = 1'b0;
                if (cursor == 4'(i)) begin
                    target_empty = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_next   = state;
        board_next   = board;
        mover_next   = mover;
        winner_next  = winner_r;
        invalid_next = 1'b0;

        if (new_game) begin
            state_next  = P1_TURN;
            board_next  = '0;
            mover_next  = CELL_P1;
            winner_next = WIN_NONE;
        end else begin
            unique case (state)
                P1_TURN, P2_TURN: begin
                    if (place_edge) begin
                        if (cursor_ok && target_empty) begin
                            for (int i = 0; i < CELLS; i++) begin
                                if (cursor == 4'(i)) begin
                                    board_next[2*i +: 2] = mark;
                                end
                            end
                            mover_next = mark;
                            state_next = CHECK;
                        end else begin
                            invalid_next = 1'b1;
                        end
                    end
                end
                // Placement edges arriving here are intentionally dropped.
                CHECK: begin
                    if (mover_won) begin
                        winner_next = (mover == CELL_P1) ? WIN_P1 : WIN_P2;
                        state_next  = DONE;
                    end else if (board_full) begin
                        winner_next = WIN_DRAW;
                        state_next  = DONE;
                    end else begin
                        state_next = (mover == CELL_P1) ? P2_TURN : P1_TURN;
                    end
                end
                DONE: begin
                    state_next = DONE;
                end
                default: begin
                    state_next = P1_TURN;
                end
            endcase
        end
    end

    // place_q starts high so a place level held across reset or new_game
    // must drop before it can count as a fresh request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= P1_TURN;
            board     <= '0;
            mover     <= CELL_P1;
            winner_r  <= WIN_NONE;
            place_q   <= 1'b1;
            player1   <= 1'b1;
            player2   <= 1'b0;
            game_over <= 1'b0;
            invalid   <= 1'b0;
        end else begin
            state     <= state_next;
            board     <= board_next;
            mover     <= mover_next;
            winner_r  <= winner_next;
            place_q   <= new_game ? 1'b1 : place;
            player1   <= (state_next == P1_TURN);
            player2   <= (state_next == P2_TURN);
            game_over <= (state_next == DONE);
            invalid   <= invalid_next;
        end
    end

    assign winner = winner_r;

endmodule

// File: tb/tb_ttt_turn_ctrl.sv
// Self-checking bench: directed game scenarios plus random play, scored
// every cycle against a board-level reference model of the game rules.
module tb_ttt_turn_ctrl;

    logic        clk;
    logic        rst_n;
    logic        place;
    logic [3:0]  cursor;
    logic        new_game;
    logic [17:0] board;
    logic        player1;
    logic        player2;
    logic [1:0]  winner;
    logic        game_over;
    logic        invalid;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: cell owners (0/1/2), whose turn it is, game phase flags.
    int m_cells [9];
    int m_turn;
    int m_mover;
    int m_win;
    bit m_checking;
    bit m_done;
    bit m_inv;
    bit m_armed;

    ttt_turn_ctrl #(.CELLS(9)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .place     (place),
        .cursor    (cursor),
        .new_game  (new_game),
        .board     (board),
        .player1   (player1),
        .player2   (player2),
        .winner    (winner),
        .game_over (game_over),
        .invalid   (invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 9; i++) m_cells[i] = 0;
        m_turn     = 1;
        m_mover    = 1;
        m_win      = 0;
        m_checking = 0;
        m_done     = 0;
        m_inv      = 0;
        m_armed    = 0;
    endtask

    function automatic bit ownsLine(input int who);
        bit hit = 0;
        for (int r = 0; r < 3; r++) begin
            if (m_cells[3*r] == who && m_cells[3*r+1] == who && m_cells[3*r+2] == who) hit = 1;
            if (m_cells[r] == who && m_cells[r+3] == who && m_cells[r+6] == who) hit = 1;
        end
        if (m_cells[0] == who && m_cells[4] == who && m_cells[8] == who) hit = 1;
        if (m_cells[2] == who && m_cells[4] == who && m_cells[6] == who) hit = 1;
        return hit;
    endfunction

    function automatic bit boardFull();
        bit full = 1;
        for (int i = 0; i < 9; i++) if (m_cells[i] == 0) full = 0;
        return full;
    endfunction

    task automatic modelStep(input bit p, input logic [3:0] c, input bit ng);
        bit edge_seen;
        int idx;
        edge_seen = p && m_armed;
        idx = int'(c);
        m_inv = 0;
        if (ng) begin
            modelReset();
        end else begin
            if (m_checking) begin
                m_checking = 0;
                if (ownsLine(m_mover)) begin
                    m_win  = m_mover;
                    m_done = 1;
                end else if (boardFull()) begin
                    m_win  = 3;
                    m_done = 1;
                end else begin
                    m_turn = 3 - m_mover;
                end
            end else if (!m_done && edge_seen) begin
                if (idx <= 8 && m_cells[idx] == 0) begin
                    m_cells[idx] = m_turn;
                    m_mover      = m_turn;
                    m_checking   = 1;
                end else begin
                    m_inv = 1;
                end
            end
            m_armed = !p;
        end
    endtask

    function automatic logic [17:0] modelBoard();
        logic [17:0] b;
        b = '0;
        for (int i = 0; i < 9; i++) b[2*i +: 2] = 2'(m_cells[i]);
        return b;
    endfunction

    task automatic checkAgainstModel();
        bit active;
        active = !m_checking && !m_done;
        checkOutput("board",     32'(board),     32'(modelBoard()));
        checkOutput("player1",   32'(player1),   32'(active && m_turn == 1));
        checkOutput("player2",   32'(player2),   32'(active && m_turn == 2));
        checkOutput("winner",    32'(winner),    32'(m_win));
        checkOutput("game_over", 32'(game_over), 32'(m_done));
        checkOutput("invalid",   32'(invalid),   32'(m_inv));
    endtask

    task automatic applyStimulus(input bit p, input logic [3:0] c, input bit ng);
        place    = p;
        cursor   = c;
        new_game = ng;
        @(posedge clk);
        #1;
        modelStep(p, c, ng);
        checkAgainstModel();
    endtask

    task automatic doMove(input logic [3:0] c);
        applyStimulus(1'b1, c, 1'b0);
        applyStimulus(1'b0, c, 1'b0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_board"},     32'(board),     32'h0);
        checkOutput({tag, "_player1"},   32'(player1),   32'h1);
        checkOutput({tag, "_player2"},   32'(player2),   32'h0);
        checkOutput({tag, "_winner"},    32'(winner),    32'h0);
        checkOutput({tag, "_game_over"}, 32'(game_over), 32'h0);
        checkOutput({tag, "_invalid"},   32'(invalid),   32'h0);
    endtask

    initial begin
        logic [17:0] saved;
        int          written;
        bit          p;
        bit          ng;
        logic [3:0]  c;

        rst_n    = 1'b0;
        place    = 1'b0;
        cursor   = 4'd0;
        new_game = 1'b0;
        modelReset();
        #12;
        checkResetValues("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // First move in the centre, then the turn passes to player 2.
        applyStimulus(1'b0, 4'd4, 1'b0);
        applyStimulus(1'b1, 4'd4, 1'b0);
        checkOutput("centre_cell", 32'(board[9:8]), 32'h1);
        applyStimulus(1'b0, 4'd4, 1'b0);
        checkOutput("centre_p2_turn", 32'(player2), 32'h1);

        // Occupied cell and out-of-range cursor are both rejected.
        applyStimulus(1'b0, 4'd0, 1'b1);
        applyStimulus(1'b0, 4'd0, 1'b0);
        doMove(4'd0);
        applyStimulus(1'b1, 4'd0, 1'b0);
        checkOutput("occupied_invalid", 32'(invalid), 32'h1);
        checkOutput("occupied_board", 32'(board), 32'h1);
        applyStimulus(1'b0, 4'd0, 1'b0);
        checkOutput("occupied_pulse_end", 32'(invalid), 32'h0);
        checkOutput("occupied_p2_turn", 32'(player2), 32'h1);
        applyStimulus(1'b1, 4'd12, 1'b0);
        checkOutput("range_invalid", 32'(invalid), 32'h1);
        applyStimulus(1'b0, 4'd12, 1'b0);
        checkOutput("range_board", 32'(board), 32'h1);
        checkOutput("range_p2_turn", 32'(player2), 32'h1);

        // Player 1 completes the top row; later requests are ignored silently.
        applyStimulus(1'b0, 4'd0, 1'b1);
        applyStimulus(1'b0, 4'd0, 1'b0);
        doMove(4'd0); doMove(4'd3); doMove(4'd1); doMove(4'd4); doMove(4'd2);
        checkOutput("row_winner", 32'(winner), 32'h1);
        checkOutput("row_game_over", 32'(game_over), 32'h1);
        saved = board;
        applyStimulus(1'b1, 4'd5, 1'b0);
        checkOutput("done_no_invalid", 32'(invalid), 32'h0);
        applyStimulus(1'b0, 4'd5, 1'b0);
        checkOutput("done_board_held", 32'(board), 32'(saved));

        // Full board without a line is a draw.
        applyStimulus(1'b0, 4'd0, 1'b1);
        applyStimulus(1'b0, 4'd0, 1'b0);
        doMove(4'd0); doMove(4'd1); doMove(4'd2); doMove(4'd4); doMove(4'd3);
        doMove(4'd5); doMove(4'd7); doMove(4'd6); doMove(4'd8);
        checkOutput("draw_winner", 32'(winner), 32'h3);
        checkOutput("draw_board", 32'(board), 32'(18'b01_01_10_10_10_01_01_10_01));

        // A held request writes once; new_game beats a simultaneous request.
        applyStimulus(1'b0, 4'd0, 1'b1);
        applyStimulus(1'b0, 4'd2, 1'b0);
        for (int k = 0; k < 20; k++) applyStimulus(1'b1, 4'd2, 1'b0);
        written = 0;
        for (int i = 0; i < 9; i++) if (board[2*i +: 2] != 2'b00) written++;
        checkOutput("held_one_write", 32'(written), 32'h1);
        checkOutput("held_board", 32'(board), 32'h10);
        applyStimulus(1'b1, 4'd5, 1'b1);
        checkOutput("ng_board", 32'(board), 32'h0);
        checkOutput("ng_player1", 32'(player1), 32'h1);
        applyStimulus(1'b1, 4'd5, 1'b0);
        checkOutput("ng_no_write", 32'(board), 32'h0);

        // Asynchronous reset while the move is being scored.
        applyStimulus(1'b0, 4'd7, 1'b0);
        applyStimulus(1'b1, 4'd7, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetValues("async_rst");
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;

        // Random play, with occasional bad cursors and fresh games.
        for (int k = 0; k < 2500; k++) begin
            p  = ($urandom_range(0, 2) != 0) ? ~place : place;
            c  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            ng = ($urandom_range(0, 60) == 0);
            applyStimulus(p, c, ng);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
